// File: rtl/muldiv_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// muldiv_seq
//
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Decodes funct3 on its own and runs either a radix-2 shift-add multiplier
// or a restoring divider. Each runs one step per clock over XLEN clocks.
// Divide-by-zero and signed-overflow divides finish straight from the
// accept edge without iterating.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operation request
//   in_ready   unit can take a request this cycle
//   funct3     M-extension operation select
//   op_a       rs1 value
//   op_b       rs2 value
//   flush      cancel the in-flight operation and drop any held result
//   out_valid  result available
//   out_ready  consumer takes the result
//   result     operation result, stable while out_valid is high
//   busy       unit is iterating
// ---------------------------------------------------------------------------
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_REM    = 3'b110;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [CW-1:0]     count_reg;
    logic [2:0]        funct3_reg;
    logic              neg_res_reg;
    // Multiply: {partial product high, multiplier shifting out}.
    // Divide:   {partial remainder, dividend shifting out / quotient in}.
    logic [2*XLEN-1:0] acc_reg;
    // Multiplicand magnitude or divisor magnitude.
    logic [XLEN-1:0]   operand_reg;
    logic [XLEN-1:0]   result_reg;
    logic              out_valid_reg;
    logic              busy_reg;

    logic              accept;

    // ------------------------------------------------------------------
    // Request decode (only meaningful in the accept cycle)
    // ------------------------------------------------------------------
    logic              is_div_in;
    logic              signed_a_in;
    logic              signed_b_in;
    logic              sign_a_in;
    logic              sign_b_in;
    logic              neg_res_in;
    logic              div_zero_in;
    logic              overflow_in;
    logic              special_in;
    logic [XLEN-1:0]   mag_a_in;
    logic [XLEN-1:0]   mag_b_in;
    logic [XLEN-1:0]   special_result_in;

    always_comb begin
        is_div_in   = funct3[2];
        signed_a_in = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                      (funct3 == F3_DIV)  || (funct3 == F3_REM);
        // MULHSU treats rs2 as unsigned, so its sign never contributes.
        signed_b_in = (funct3 == F3_MULH) || (funct3 == F3_DIV) ||
                      (funct3 == F3_REM);
        sign_a_in   = signed_a_in & op_a[XLEN-1];
        sign_b_in   = signed_b_in & op_b[XLEN-1];

        // Negating the most-negative value yields the same bit pattern,
        // which read as unsigned is exactly its magnitude.
        mag_a_in = sign_a_in ? -op_a : op_a;
        mag_b_in = sign_b_in ? -op_b : op_b;

        if (!is_div_in) begin
            neg_res_in = sign_a_in ^ sign_b_in;
        end else if (!funct3[1]) begin
            neg_res_in = sign_a_in ^ sign_b_in;   // quotient
        end else begin
            neg_res_in = sign_a_in;               // remainder follows dividend
        end

        div_zero_in = is_div_in && (op_b == '0);
        overflow_in = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                      (op_a == MOST_NEG) && (op_b == '1);
        special_in  = div_zero_in | overflow_in;

        if (div_zero_in) begin
            special_result_in = funct3[1] ? op_a : '1;
        end else begin
            special_result_in = funct3[1] ? '0 : op_a;
        end
    end

    // ------------------------------------------------------------------
    // One iteration step plus the sign fix-up applied on the last step
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_shift;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] step_acc;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   div_val;
    logic [XLEN-1:0]   div_res;
    logic [XLEN-1:0]   final_result;

    always_comb begin
        acc_hi = acc_reg[2*XLEN-1:XLEN];
        acc_lo = acc_reg[XLEN-1:0];

        // Shift-add: add the multiplicand into the high half when the
        // current multiplier bit is set, then shift the whole thing right.
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_reg} : '0);
        mul_next = {mul_sum, acc_lo[XLEN-1:1]};

        // Restoring divide: bring in the next dividend bit and subtract the
        // divisor only if it fits. The difference is below the divisor, so
        // its low XLEN bits are the whole value.
        rem_shift = {acc_hi, acc_lo[XLEN-1]};
        rem_ge    = rem_shift >= {1'b0, operand_reg};
        rem_diff  = rem_shift[XLEN-1:0] - operand_reg;
        div_next  = {(rem_ge ? rem_diff : rem_shift[XLEN-1:0]),
                     acc_lo[XLEN-2:0], rem_ge};

        step_acc = funct3_reg[2] ? div_next : mul_next;

        prod    = neg_res_reg ? -step_acc : step_acc;
        div_val = funct3_reg[1] ? step_acc[2*XLEN-1:XLEN] : step_acc[XLEN-1:0];
        div_res = neg_res_reg ? -div_val : div_val;

        if (!funct3_reg[2]) begin
            final_result = (funct3_reg[1:0] == 2'b00) ? prod[XLEN-1:0]
                                                      : prod[2*XLEN-1:XLEN];
        end else begin
            final_result = div_res;
        end
    end

    // DONE with a taken result frees the unit in the same edge.
    assign in_ready = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept   = in_valid && in_ready && !flush;

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            funct3_reg    <= '0;
            neg_res_reg   <= 1'b0;
            acc_reg       <= '0;
            operand_reg   <= '0;
            result_reg    <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else if (flush) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else if (accept) begin
            funct3_reg  <= funct3;
            neg_res_reg <= neg_res_in;
            count_reg   <= '0;
            if (special_in) begin
                state_reg     <= DONE;
                result_reg    <= special_result_in;
                out_valid_reg <= 1'b1;
                busy_reg      <= 1'b0;
            end else begin
                state_reg     <= BUSY;
                out_valid_reg <= 1'b0;
                busy_reg      <= 1'b1;
                if (is_div_in) begin
                    acc_reg     <= {{XLEN{1'b0}}, mag_a_in};
                    operand_reg <= mag_b_in;
                end else begin
                    acc_reg     <= {{XLEN{1'b0}}, mag_b_in};
                    operand_reg <= mag_a_in;
                end
            end
        end else begin
            case (state_reg)
                BUSY: begin
                    acc_reg   <= step_acc;
                    count_reg <= count_reg + CW'(1);
                    // The final step's output is sign-corrected and
                    // registered in the same edge that enters DONE.
                    if (count_reg == CW'(XLEN - 1)) begin
                        state_reg     <= DONE;
                        result_reg    <= final_result;
                        out_valid_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign result    = result_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for muldiv_seq: a driver issues operations and pushes the
// expected result, a monitor pops and compares at each output handshake.
module tb_muldiv_seq;

    localparam int XLEN = 32;

    localparam logic [2:0] MUL    = 3'd0;
    localparam logic [2:0] MULH   = 3'd1;
    localparam logic [2:0] MULHSU = 3'd2;
    localparam logic [2:0] MULHU  = 3'd3;
    localparam logic [2:0] DIV    = 3'd4;
    localparam logic [2:0] DIVU   = 3'd5;
    localparam logic [2:0] REM    = 3'd6;
    localparam logic [2:0] REMU   = 3'd7;

    logic            clk;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    int   last_acc = 0;

    // 0: out_ready always 1, 1: random, 2: held low
    int rdy_ctl = 0;

    always @(negedge clk) begin
        if (rdy_ctl == 0)      out_ready = 1'b1;
        else if (rdy_ctl == 1) out_ready = 1'($urandom_range(0, 1));
        else                   out_ready = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: plain wide arithmetic following the M-extension rules.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb2, ua, ub, p;
        int ia, ib;
        sa  = {{32{a[31]}}, a};
        sb2 = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ia  = a;
        ib  = b;
        case (f3)
            MUL:    begin p = sa * sb2; return p[31:0];  end
            MULH:   begin p = sa * sb2; return p[63:32]; end
            MULHSU: begin p = sa * ub;  return p[63:32]; end
            MULHU:  begin p = ua * ub;  return p[63:32]; end
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Presents a request from the next falling edge until it is accepted;
    // leaves in_valid high so a following call can issue back-to-back.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit score, input logic [31:0] exp_res, input int exp_lat);
        exp_t e;
        int   waitc = 0;
        @(negedge clk);
        in_valid = 1'b1;
        funct3   = f3;
        op_a     = a;
        op_b     = b;
        #1;
        while (!in_ready && waitc < 300) begin
            waitc++;
            @(negedge clk);
            #1;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
        last_acc = cyc + 1;
        if (score) begin
            e.res = exp_res;
            e.acc = last_acc;
            e.lat = exp_lat;
            e.f3  = f3;
            e.a   = a;
            e.b   = b;
            sb.push_back(e);
        end
    endtask

    task automatic issue_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        issue(f3, a, b, 1'b1, model(f3, a, b), is_special(f3, a, b) ? 1 : 33);
    endtask

    // Drop the request and scramble the operands to show they are not used.
    task automatic quiet();
        @(negedge clk);
        in_valid = 1'b0;
        funct3   = 3'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
    endtask

    // Monitor: records when each result first appears, pops at handshake.
    bit   seen  = 1'b0;
    int   first = 0;
    exp_t m;
    always @(negedge clk) begin
        #2;
        if (!reset_n || flush) begin
            seen = 1'b0;
        end else begin
            if (out_valid && !seen) begin
                seen  = 1'b1;
                first = cyc;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output actual=%h required=none", result);
                end else begin
                    m = sb.pop_front();
                    check("result", result, m.res);
                    check("latency", 32'(first - m.acc + 1), 32'(m.lat));
                    $display("txn f3=%0d a=%h b=%h result=%h expected=%h latency=%0d",
                             m.f3, m.a, m.b, result, m.res, first - m.acc + 1);
                end
                seen = 1'b0;
            end
        end
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int w;
        int vcnt;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        funct3   = 3'd0;
        op_a     = '0;
        op_b     = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Known vectors with independently stated results
        vecs.push_back('{MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
        vecs.push_back('{MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33});
        vecs.push_back('{MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
        vecs.push_back('{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
        vecs.push_back('{DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33});
        vecs.push_back('{REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33});
        vecs.push_back('{DIVU,   32'd100,        32'd7,         32'd14,        33});
        vecs.push_back('{REMU,   32'd100,        32'd7,         32'd2,         33});
        vecs.push_back('{DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{REM,    32'd5,          32'd0,         32'd5,         1});
        vecs.push_back('{DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});
        rdy_ctl = 0;
        foreach (vecs[i]) begin
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, 1'b1, vecs[i].res, vecs[i].lat);
            quiet();
        end

        // Randomized operations with random backpressure and gaps
        rdy_ctl = 1;
        for (int i = 0; i < 60; i++) begin
            issue_model(3'($urandom_range(0, 7)), rnd_op(), rnd_op());
            if ($urandom_range(0, 2) == 0) quiet();
        end
        quiet();
        rdy_ctl = 0;
        w = 0;
        while (sb.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end

        // Backpressure: hold the result, then consume and accept together
        rdy_ctl = 2;
        issue(DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 33);
        quiet();
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            #3;
            w++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #3;
            check("hold_result", result, 32'd14);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        rdy_ctl = 0;
        issue(DIVU, 32'd9, 32'd0, 1'b1, 32'hFFFF_FFFF, 1);
        quiet();
        #3;
        check("b2b_out_valid", 32'(out_valid), 32'd1);
        check("b2b_result", result, 32'hFFFF_FFFF);

        // Flush mid-divide, with a special-case request in the flush cycle
        issue(DIV, 32'd1000, 32'd3, 1'b0, 32'd0, 0);
        quiet();
        repeat (8) @(negedge clk);
        #3;
        check("pre_flush_busy", 32'(busy), 32'd1);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        funct3   = DIVU;
        op_a     = 32'd5;
        op_b     = 32'd0;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #3;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        vcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #3;
            if (out_valid) vcnt++;
        end
        check("flush_no_valid", 32'(vcnt), 32'd0);
        issue(MUL, 32'd3, 32'd4, 1'b1, 32'd12, 33);
        quiet();
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end

        // Flush drops a held result
        rdy_ctl = 2;
        issue(DIVU, 32'd7, 32'd0, 1'b0, 32'd0, 0);
        quiet();
        #3;
        check("held_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #3;
        check("flushed_held_valid", 32'(out_valid), 32'd0);
        check("flushed_in_ready", 32'(in_ready), 32'd1);
        rdy_ctl = 0;

        // Asynchronous reset in the middle of a multiply
        issue(MUL, 32'd5, 32'd6, 1'b0, 32'd0, 0);
        quiet();
        repeat (4) @(negedge clk);
        #2;
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset_in_ready", 32'(in_ready), 32'd1);
        check("async_reset_out_valid", 32'(out_valid), 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_result", result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Recovery after reset
        issue_model(REMU, 32'd100, 32'd7);
        issue_model(MULH, 32'hFFFF_FFFE, 32'd3);
        quiet();

        w = 0;
        while (sb.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
